// File: rtl/mem_sig_reader.sv
// mem_sig_reader: reads the word range [start_addr, end_addr) over the req/gnt/rvalid host port and streams it out.
// Optional running checksum of streamed words is enabled by defining MEM_SIG_READER_CHECKSUM_EN.
module mem_sig_reader #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned FifoDepth      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] start_addr_i,
  input  logic [AddrWidth-1:0] end_addr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  input  logic                 host_err_i,
  output logic                 sig_valid_o,
  input  logic                 sig_ready_i,
  output logic [DataWidth-1:0] sig_data_o,
  output logic                 sig_last_o,
  output logic [DataWidth-1:0] checksum_o
);

  localparam int unsigned WW = AddrWidth - 2;
  localparam int unsigned PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CW = $clog2(FifoDepth + 1);
  localparam int unsigned OW = $clog2(MaxOutstanding + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [WW-1:0]        addr_q, addr_d;
  logic [WW-1:0]        end_q, end_d;
  logic [WW-1:0]        wcnt_q, wcnt_d;
  logic [WW-1:0]        pcnt_q, pcnt_d;
  logic [OW-1:0]        out_q, out_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic                 err_q, err_d;
  logic [DataWidth-1:0] mem_q [2**PW];

  logic                 start_ok, credit, grant, push, pop, last_word;
  logic [WW-1:0]        start_w, end_w, addr_inc;
  logic [DataWidth-1:0] push_data;
  logic                 unused_lsbs;

  assign unused_lsbs = ^{start_addr_i[1:0], end_addr_i[1:0]};

  assign start_w  = start_addr_i[AddrWidth-1:2];
  assign end_w    = end_addr_i[AddrWidth-1:2];
  assign addr_inc = addr_q + WW'(1);

  // Credit counts buffered plus in-flight words, so every response is guaranteed a FIFO slot.
  assign credit     = (32'(out_q) < MaxOutstanding) &&
                      ((32'(out_q) + 32'(cnt_q)) < FifoDepth);
  assign host_req_o = (state_q == S_ISSUE) && credit;
  assign grant      = host_req_o && host_gnt_i;
  assign push       = host_rvalid_i && (out_q != '0);
  assign push_data  = host_err_i ? DataWidth'(32'hDEAD_BEEF) : host_rdata_i;
  assign start_ok   = (state_q == S_IDLE) && start_i;

  assign sig_valid_o = (cnt_q != '0);
  assign pop         = sig_valid_o && sig_ready_i;
  assign last_word   = ((pcnt_q + WW'(1)) == wcnt_q);
  assign sig_data_o  = mem_q[rptr_q];
  assign sig_last_o  = sig_valid_o && last_word;

  assign busy_o       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = err_q;
  assign host_addr_o  = {addr_q, 2'b00};
  assign host_we_o    = 1'b0;
  assign host_be_o    = 4'hF;
  assign host_wdata_o = '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    wcnt_d  = wcnt_q;
    pcnt_d  = pop ? pcnt_q + WW'(1) : pcnt_q;
    out_d   = out_q + OW'(grant) - OW'(push);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = start_w;
          end_d   = end_w;
          pcnt_d  = '0;
          err_d   = 1'b0;
          if (start_w < end_w) begin
            wcnt_d  = end_w - start_w;
            state_d = S_ISSUE;
          end else begin
            wcnt_d  = '0;
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (grant) begin
          addr_d = addr_inc;
          if (addr_inc == end_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && last_word) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Error responses and responses with nothing outstanding both leave a sticky flag.
    if (host_rvalid_i && (host_err_i || (out_q == '0))) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      wcnt_q  <= wcnt_d;
      pcnt_q  <= pcnt_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 2**PW; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

`ifdef MEM_SIG_READER_CHECKSUM_EN
  logic [DataWidth-1:0] sum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + sig_data_o;
    end
  end

  assign checksum_o = sum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_mem_sig_reader.sv
// Bench for mem_sig_reader: cycle-stepped bus/RAM responder and stream sink checked against a word-list model.
module tb_mem_sig_reader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] start_addr_i = '0;
  logic [31:0] end_addr_i = '0;
  logic        busy_o, done_o, err_o;
  logic        host_req_o;
  logic        host_gnt_i = 1'b0;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_wdata_o;
  logic        host_rvalid_i = 1'b0;
  logic [31:0] host_rdata_i = '0;
  logic        host_err_i = 1'b0;
  logic        sig_valid_o;
  logic        sig_ready_i = 1'b0;
  logic [31:0] sig_data_o;
  logic        sig_last_o;
  logic [31:0] checksum_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] ram [4096];

  always #5 clk_i = ~clk_i;

  mem_sig_reader #(
    .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2), .FifoDepth(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
    .sig_valid_o(sig_valid_o), .sig_ready_i(sig_ready_i), .sig_data_o(sig_data_o),
    .sig_last_o(sig_last_o), .checksum_o(checksum_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic abort_check(input string nm);
    rst_i = 1'b1;
    start_i = 1'b0; host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0; sig_ready_i = 1'b0;
    #1;
    chk({nm, "/rst_req"}, 32'(host_req_o), 32'd0);
    chk({nm, "/rst_addr"}, host_addr_o, 32'd0);
    chk({nm, "/rst_valid"}, 32'(sig_valid_o), 32'd0);
    chk({nm, "/rst_data"}, sig_data_o, 32'd0);
    chk({nm, "/rst_last"}, 32'(sig_last_o), 32'd0);
    chk({nm, "/rst_done"}, 32'(done_o), 32'd0);
    chk({nm, "/rst_busy"}, 32'(busy_o), 32'd0);
    chk({nm, "/rst_err"}, 32'(err_o), 32'd0);
    chk({nm, "/rst_cksum"}, checksum_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk({nm, "/post_rst_done"}, 32'(done_o), 32'd0);
      chk({nm, "/post_rst_valid"}, 32'(sig_valid_o), 32'd0);
      chk({nm, "/post_rst_req"}, 32'(host_req_o), 32'd0);
    end
  endtask

  // One dump: the model is the list of words in the range plus simple grant/response/pop counts.
  task automatic run_dump(input string nm, input logic [31:0] sa, input logic [31:0] ea,
                          input int gstall, input int lat, input int err_idx,
                          input int hold, input bit rnd, input int abort_at);
    logic [31:0] exp_q[$];
    int          due_q[$];
    int          idx_q[$];
    int unsigned sw, ew;
    int          n, granted, resps, pops, stall, first_hs, last_hs, k;
    logic [31:0] sum;
    bit          err_seen, fin, exp_done, cred, gnt;

    sw = sa >> 2;
    ew = ea >> 2;
    n  = (sw < ew) ? int'(ew - sw) : 0;
    for (int i = 0; i < n; i++)
      exp_q.push_back((i == err_idx) ? 32'hDEAD_BEEF : ram[(sw + i) % 4096]);
    granted = 0; resps = 0; pops = 0; stall = 0; first_hs = -10; last_hs = -10;
    sum = '0; err_seen = 1'b0; fin = 1'b0;

    @(negedge clk_i);
    start_i = 1'b1; start_addr_i = sa; end_addr_i = ea;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk_i);
      if (c == 1) start_i = 1'b0;
      cred     = ((granted - resps) < 2) && ((granted - pops) < 4);
      exp_done = (pops == n) && ((n == 0) ? (c == 1) : (last_hs == c - 1));

      chk({nm, "/done"}, 32'(done_o), 32'(exp_done));
      chk({nm, "/req"}, 32'(host_req_o), 32'((granted < n) && cred));
      if (host_req_o === 1'b1)
        chk({nm, "/addr"}, host_addr_o, (sa & ~32'h3) + 32'(granted) * 32'd4);
      chk({nm, "/valid"}, 32'(sig_valid_o), 32'((resps - pops) > 0));
      if (sig_valid_o === 1'b1 && pops < n) begin
        chk({nm, "/data"}, sig_data_o, exp_q[pops]);
        chk({nm, "/last"}, 32'(sig_last_o), 32'(pops == n - 1));
      end
      chk({nm, "/err"}, 32'(err_o), 32'(err_seen));
`ifdef MEM_SIG_READER_CHECKSUM_EN
      chk({nm, "/cksum"}, checksum_o, sum);
`else
      chk({nm, "/cksum"}, checksum_o, 32'd0);
`endif
      if (n > 0 && !exp_done) chk({nm, "/busy"}, 32'(busy_o), 32'd1);

      if (exp_done || done_o === 1'b1) begin
        fin = 1'b1;
        start_i = 1'b0; host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0;
        break;
      end
      if (abort_at >= 0 && pops == abort_at) begin
        abort_check(nm);
        return;
      end

      host_gnt_i = 1'b0;
      if (host_req_o === 1'b1) begin
        gnt = rnd ? ($urandom_range(0, 2) != 0) : (stall >= gstall);
        if (gnt) begin
          host_gnt_i = 1'b1;
          due_q.push_back(c + (rnd ? int'($urandom_range(1, lat)) : lat));
          idx_q.push_back(granted);
          granted++;
          stall = 0;
        end else begin
          stall++;
        end
      end

      host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = $urandom;
      if (due_q.size() > 0 && due_q[0] <= c) begin
        k = idx_q.pop_front();
        void'(due_q.pop_front());
        host_rvalid_i = 1'b1;
        host_rdata_i  = ram[(sw + k) % 4096];
        host_err_i    = (k == err_idx);
        if (k == err_idx) err_seen = 1'b1;
        resps++;
      end

      sig_ready_i = rnd ? ($urandom_range(0, 3) != 0) : (c > hold);
      if (rnd) begin
        start_i = 1'($urandom_range(0, 1));
        start_addr_i = $urandom;
        end_addr_i = $urandom;
      end
      if (sig_valid_o === 1'b1 && sig_ready_i && pops < n) begin
        sum = sum + exp_q[pops];
        if (pops == 0) first_hs = c;
        last_hs = c;
        pops++;
      end
    end

    chk({nm, "/finished"}, 32'(fin), 32'd1);
    if (fin) begin
      chk({nm, "/count"}, 32'(pops), 32'(n));
      if (n > 0 && !rnd && gstall == 0 && lat == 1 && hold == 0)
        chk({nm, "/throughput"}, 32'(last_hs - first_hs), 32'(n - 1));
      @(negedge clk_i);
      chk({nm, "/done_pulse"}, 32'(done_o), 32'd0);
      chk({nm, "/idle_busy"}, 32'(busy_o), 32'd0);
      chk({nm, "/idle_valid"}, 32'(sig_valid_o), 32'd0);
      chk({nm, "/err_hold"}, 32'(err_o), 32'(err_seen));
`ifdef MEM_SIG_READER_CHECKSUM_EN
      chk({nm, "/cksum_hold"}, checksum_o, sum);
`else
      chk({nm, "/cksum_hold"}, checksum_o, 32'd0);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sa, ea;
    int          len, eidx;

    for (int i = 0; i < 4096; i++) ram[i] = $urandom;
    for (int i = 0; i < 4; i++) ram[(32'h1000 >> 2) + i] = 32'(i + 1);

    repeat (2) @(negedge clk_i);
    chk("reset/req", 32'(host_req_o), 32'd0);
    chk("reset/busy", 32'(busy_o), 32'd0);
    chk("reset/done", 32'(done_o), 32'd0);
    chk("reset/err", 32'(err_o), 32'd0);
    chk("reset/valid", 32'(sig_valid_o), 32'd0);
    chk("reset/data", sig_data_o, 32'd0);
    chk("reset/cksum", checksum_o, 32'd0);
    chk("reset/we", 32'(host_we_o), 32'd0);
    chk("reset/be", 32'(host_be_o), 32'hF);
    chk("reset/wdata", host_wdata_o, 32'd0);
    rst_i = 1'b0;

    run_dump("basic", 32'h1000, 32'h1010, 0, 1, -1, 0, 1'b0, -1);
`ifdef MEM_SIG_READER_CHECKSUM_EN
    chk("basic/cksum10", checksum_o, 32'd10);
`endif
    run_dump("empty", 32'h2000, 32'h2000, 0, 1, -1, 0, 1'b0, -1);
    run_dump("end_zero", 32'h0040, 32'h0000, 0, 1, -1, 0, 1'b0, -1);
    run_dump("unaligned", 32'h1003, 32'h100D, 0, 1, -1, 0, 1'b0, -1);
    run_dump("backpressure", 32'h3000, 32'h3020, 0, 1, -1, 20, 1'b0, -1);
    run_dump("gnt_stall", 32'h1100, 32'h1110, 5, 2, -1, 0, 1'b0, -1);

    // A response with nothing outstanding is dropped but flagged.
    @(negedge clk_i);
    host_rvalid_i = 1'b1; host_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    host_rvalid_i = 1'b0;
    chk("stray/err", 32'(err_o), 32'd1);
    chk("stray/valid", 32'(sig_valid_o), 32'd0);

    run_dump("err_resp", 32'h1200, 32'h120C, 0, 1, 1, 0, 1'b0, -1);
    run_dump("err_clear", 32'h1240, 32'h1248, 0, 3, -1, 0, 1'b0, -1);
    run_dump("reset_mid", 32'h1300, 32'h1320, 0, 2, -1, 0, 1'b0, 2);
    run_dump("after_rst", 32'h1300, 32'h1320, 0, 2, -1, 0, 1'b0, -1);

    for (int t = 0; t < 12; t++) begin
      len  = int'($urandom_range(0, 12));
      sa   = 32'($urandom_range(0, 32'h3F00));
      ea   = ((sa & ~32'h3) + 32'(len) * 32'd4) | 32'($urandom_range(0, 3));
      eidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_dump("random", sa, ea, 0, 3, eidx, 0, 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
